rf_nrmw: RTL and testbench
==========================

# rf_nrmw

Parametrised multi-port register file: the next generation of the 2-read/1-write register file. It has N_RD combinational read ports, N_WR write ports with fixed priority, optional write-to-read bypass, an optional hardwired zero register, and a per-entry pending (scoreboard) bit. The pending bits let the issue stage detect read-after-write hazards. The block sits between decode/issue (read and reserve) and writeback (write) in the core pipeline.

## Interface
Parameters:
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports (≥1)
- N_WR, 1, number of write ports (≥1)
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes, is never pending
- BYPASS, 0, 1 = same-cycle write data is forwarded to read ports

Ports (port k occupies slice [k*W +: W] of each flat bus):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- i_rd_addr  in  N_RD*ADDR_W  read addresses
- o_rd_data  out  N_RD*DATA_W  read data
- o_rd_pend  out  N_RD  pending bit of each read address
- i_wr_addr  in  N_WR*ADDR_W  write addresses
- i_wr_data  in  N_WR*DATA_W  write data
- i_wr_en  in  N_WR  write enables
- i_rsv_addr  in  ADDR_W  reserve address (marks entry pending)
- i_rsv_en  in  1  reserve enable

## Operation
- Storage: 2**ADDR_W × DATA_W flops, plus a pending vector of 2**ADDR_W flops.
- Reset: at a clk edge with rst=1, all entries become 0 and all pending bits clear. Writes and reserves in that cycle are discarded.
- Reset values of outputs: after the reset edge, o_rd_data = 0 and o_rd_pend = 0 for every address until the next write or reserve.
- Write: at a clk edge with wr_en[j]=1, entry wr_addr[j] takes wr_data[j], and its pending bit clears.
- Write conflict: if several enabled ports hit the same address, the highest port index wins. Only one value is stored; no error is flagged.
- Reserve: at a clk edge with i_rsv_en=1, pend[i_rsv_addr] is set.
- Reserve and write to the same address in the same cycle: the reserve wins, and the pending bit ends set. The data write still happens.
- Reads are combinational: o_rd_data[k] = mem[rd_addr[k]] and o_rd_pend[k] = pend[rd_addr[k]]. All read ports are independent; the same address may be read on every port.
- BYPASS=1: if any enabled write port targets rd_addr[k] in the current cycle, o_rd_data[k] is the winning (highest-index) wr_data, and o_rd_pend[k] = 0. A same-cycle reserve does not affect this output.
- BYPASS=0: read data reflects only state latched at prior edges.
- ZERO_REG=1: address 0 always returns data 0 and pend 0, bypass included. Writes and reserves to address 0 are ignored.
- X-free: no output is X after the first reset edge for any in-range address.

## Timing
- Write-to-read latency: 1 edge (BYPASS=0), 0 cycles (BYPASS=1).
- Reserve-to-pend visible: 1 edge, never bypassed.
- Write-to-pend clear: 1 edge (BYPASS=0), 0 cycles on the bypassed port (BYPASS=1).
- Read path: purely combinational from addresses, stored state and, when BYPASS=1, the write inputs. No clocked output registers.
- rst asserted mid-operation: takes effect at the next edge and overrides all same-cycle activity. While rst=1, reads show the pre-reset contents until that edge.

## Test plan
- Reset: write 0xAB to entry 16, assert rst for one edge, read ports 0/1 at 16 → data 0, pend 0.
- Basic: write 0xAB→16 and 0xCD→31 on successive edges, then read 16/31 → 0xAB/0xCD. Read both ports at 31 → 0xCD on both.
- Conflict (N_WR=2): same edge, port0 writes 0x11→5 and port1 writes 0x22→5, then read 5 → 0x22.
- Bypass (BYPASS=1): with wr_en=1, addr 7, data 0xEF, and rd_addr=7 before the edge → o_rd_data=0xEF in the same cycle. With BYPASS=0 → old value until after the edge.
- Scoreboard: reserve 9 → pend=1 after the edge. Write 9 with 0x5A → pend=0 and data 0x5A after the edge. Reserve and write 9 on the same edge → pend=1.
- Zero reg (ZERO_REG=1): write 0xFF→0 and reserve 0, then read 0 on all ports → data 0, pend 0, including the same-cycle bypass case.

Source files
------------

// File: rtl/rf_nrmw.sv
// rf_nrmw: multi-port register file with write priority, optional
// write-to-read bypass, optional hardwired zero entry and a per-entry
// pending (scoreboard) bit for read-after-write hazard detection.
module rf_nrmw #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int N_WR     = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [N_RD*DATA_W-1:0]   o_rd_data,
  output logic [N_RD-1:0]          o_rd_pend,
  input  logic [N_WR*ADDR_W-1:0]   i_wr_addr,
  input  logic [N_WR*DATA_W-1:0]   i_wr_data,
  input  logic [N_WR-1:0]          i_wr_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  input  logic                     i_rsv_en
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  logic [ADDR_W-1:0] rd_addr [N_RD];
  logic [ADDR_W-1:0] wr_addr [N_WR];
  logic [DATA_W-1:0] wr_data [N_WR];

  for (genvar k = 0; k < N_RD; k++) begin : g_rd_unpack
    assign rd_addr[k] = i_rd_addr[k*ADDR_W +: ADDR_W];
  end

  for (genvar j = 0; j < N_WR; j++) begin : g_wr_unpack
    assign wr_addr[j] = i_wr_addr[j*ADDR_W +: ADDR_W];
    assign wr_data[j] = i_wr_data[j*DATA_W +: DATA_W];
  end

  // Next state: writes in ascending port order so the highest index wins;
  // the reserve is applied last so it beats a same-cycle write on pend.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    pend_d = pend_q;
    for (int j = 0; j < N_WR; j++) begin
      if (i_wr_en[j]) begin
        mem_d[wr_addr[j]]  = wr_data[j];
        pend_d[wr_addr[j]] = 1'b0;
      end
    end
    if (i_rsv_en) pend_d[i_rsv_addr] = 1'b1;
    if (ZERO_REG != 0) begin
      mem_d[0]  = '0;
      pend_d[0] = 1'b0;
    end
  end

  // State registers; reset discards any same-cycle write or reserve.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      pend_q <= pend_d;
    end
  end

  // Combinational read ports with optional bypass; the zero entry overrides
  // everything, including a bypassed write to address 0.
  always_comb begin
    o_rd_data = '0;
    o_rd_pend = '0;
    for (int k = 0; k < N_RD; k++) begin
      o_rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr[k]];
      o_rd_pend[k]                  = pend_q[rd_addr[k]];
      if (BYPASS != 0) begin
        for (int j = 0; j < N_WR; j++) begin
          if (i_wr_en[j] && (wr_addr[j] == rd_addr[k])) begin
            o_rd_data[k*DATA_W +: DATA_W] = wr_data[j];
            o_rd_pend[k]                  = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[k] == '0)) begin
        o_rd_data[k*DATA_W +: DATA_W] = '0;
        o_rd_pend[k]                  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_nrmw.sv
// Directed bench for rf_nrmw: one bypassing and one non-bypassing instance,
// both with two write ports and the zero register, sharing all inputs.
module tb_rf_nrmw;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_en;
  logic [4:0]  rsv_addr;
  logic        rsv_en;

  logic [63:0] rdd_b, rdd_n;
  logic [1:0]  rdp_b, rdp_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_nrmw #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .N_WR(2), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst),
    .i_rd_addr(rd_addr), .o_rd_data(rdd_b), .o_rd_pend(rdp_b),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .i_rsv_addr(rsv_addr), .i_rsv_en(rsv_en)
  );

  rf_nrmw #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .N_WR(2), .ZERO_REG(1), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst),
    .i_rd_addr(rd_addr), .o_rd_data(rdd_n), .o_rd_pend(rdp_n),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .i_rsv_addr(rsv_addr), .i_rsv_en(rsv_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    rsv_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_addr[p*5 +: 5]  = a;
    wr_data[p*32 +: 32] = d;
    wr_en[p]           = 1'b1;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_addr = a;
    rsv_en   = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0;
    wr_en = '0; rsv_addr = '0; rsv_en = 1'b0;
    tick();
    rst = 1'b0;

    // Reset state
    rd(5'd16, 5'd31); settle();
    chk("rst_data0", rdd_n[31:0], 32'h0);
    chk("rst_data1", rdd_n[63:32], 32'h0);
    chk("rst_pend", {30'h0, rdp_n}, 32'h0);
    chk("rst_data_b", rdd_b[31:0], 32'h0);

    // Write then reset; reset also discards a same-cycle write and reserve
    wr(0, 5'd16, 32'hAB); tick(); idle();
    rd(5'd16, 5'd16); settle();
    chk("wr16_pre_rst", rdd_n[31:0], 32'hAB);
    rst = 1'b1; wr(0, 5'd16, 32'h77); rsv(5'd16); settle();
    chk("rst_hold_old", rdd_n[63:32], 32'hAB);
    tick(); rst = 1'b0; idle(); settle();
    chk("rst16_data0", rdd_n[31:0], 32'h0);
    chk("rst16_data1", rdd_n[63:32], 32'h0);
    chk("rst16_pend", {30'h0, rdp_n}, 32'h0);

    // Basic writes on successive edges
    wr(0, 5'd16, 32'hAB); tick(); idle();
    wr(0, 5'd31, 32'hCD); tick(); idle();
    rd(5'd16, 5'd31); settle();
    chk("basic16", rdd_n[31:0], 32'hAB);
    chk("basic31", rdd_n[63:32], 32'hCD);
    rd(5'd31, 5'd31); settle();
    chk("dual31_p0", rdd_n[31:0], 32'hCD);
    chk("dual31_p1", rdd_n[63:32], 32'hCD);

    // Write conflict: port 1 wins
    wr(0, 5'd5, 32'h11); wr(1, 5'd5, 32'h22); tick(); idle();
    rd(5'd5, 5'd5); settle();
    chk("conflict_n", rdd_n[31:0], 32'h22);
    chk("conflict_b", rdd_b[63:32], 32'h22);

    // Bypass on a pending entry
    rsv(5'd7); tick(); idle();
    rd(5'd7, 5'd16); settle();
    chk("rsv7_pend", {31'h0, rdp_n[0]}, 32'h1);
    wr(0, 5'd7, 32'hEF); rsv(5'd7); settle();
    chk("byp_data", rdd_b[31:0], 32'hEF);
    chk("byp_pend", {31'h0, rdp_b[0]}, 32'h0);
    chk("nobyp_data", rdd_n[31:0], 32'h0);
    chk("nobyp_pend", {31'h0, rdp_n[0]}, 32'h1);
    chk("byp_other_port", rdd_b[63:32], 32'hAB);
    tick(); idle(); settle();
    chk("after7_data", rdd_n[31:0], 32'hEF);
    chk("after7_pend_rsv", {31'h0, rdp_n[0]}, 32'h1);

    // Bypass with two ports hitting the same address
    wr(0, 5'd12, 32'h10); wr(1, 5'd12, 32'h20); rd(5'd12, 5'd5); settle();
    chk("byp_prio", rdd_b[31:0], 32'h20);
    chk("nobyp_prio", rdd_n[31:0], 32'h0);
    tick(); idle(); settle();
    chk("after12", rdd_n[31:0], 32'h20);

    // Scoreboard
    rd(5'd16, 5'd9);
    rsv(5'd9); settle();
    chk("rsv9_not_byp", {31'h0, rdp_b[1]}, 32'h0);
    tick(); idle(); settle();
    chk("rsv9_pend", {31'h0, rdp_n[1]}, 32'h1);
    chk("rsv9_other", {31'h0, rdp_n[0]}, 32'h0);
    wr(0, 5'd9, 32'h5A); tick(); idle(); settle();
    chk("wr9_pend", {31'h0, rdp_n[1]}, 32'h0);
    chk("wr9_data", rdd_n[63:32], 32'h5A);
    wr(1, 5'd9, 32'h6B); rsv(5'd9); tick(); idle(); settle();
    chk("rsvwr9_pend", {31'h0, rdp_n[1]}, 32'h1);
    chk("rsvwr9_data", rdd_n[63:32], 32'h6B);

    // Zero register
    rd(5'd0, 5'd0);
    wr(0, 5'd0, 32'hFF); wr(1, 5'd0, 32'hEE); rsv(5'd0); settle();
    chk("zero_byp_data", rdd_b[31:0], 32'h0);
    chk("zero_byp_pend", {30'h0, rdp_b}, 32'h0);
    tick(); idle(); settle();
    chk("zero_data_n", rdd_n[63:32], 32'h0);
    chk("zero_pend_n", {30'h0, rdp_n}, 32'h0);
    chk("zero_data_b", rdd_b[31:0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
